// File: rtl/vram_console_writer_pkg.sv
// rtl/vram_console_writer_pkg.sv - shared constants, state encoding and cell-offset helper for the console writer
package vram_console_writer_pkg;

  localparam logic [15:0] VRAM_BASE_DEF = 16'h2000;
  localparam int          COLS_DEF      = 80;
  localparam int          ROWS_DEF      = 30;
  localparam logic [7:0]  BLANK_DEF     = 8'h20;

  localparam logic [7:0]  ASCII_BS = 8'h08;
  localparam logic [7:0]  ASCII_LF = 8'h0A;
  localparam logic [7:0]  ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PUT         = 2'd1,
    ST_FILL_LINE   = 2'd2,
    ST_FILL_SCREEN = 2'd3
  } state_t;

  // row*80 + col as a shift-add; fits in 12 bits for every legal cursor
  function automatic logic [11:0] cell_offset(input logic [4:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vram_console_writer.sv
// rtl/vram_console_writer.sv - terminal-style byte stream to text VRAM writer with cursor and line/screen fills
module vram_console_writer
  import vram_console_writer_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = VRAM_BASE_DEF,
  parameter int          COLS      = COLS_DEF,
  parameter int          ROWS      = ROWS_DEF,
  parameter logic [7:0]  BLANK     = BLANK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_w_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        w_en_d;
  logic [15:0] addr_d;
  logic [7:0]  dout_d;
  logic [4:0]  row_next;

  assign char_ready = (state_q == ST_IDLE) && !clear;
  assign busy       = (state_q != ST_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // no scrolling: advancing past the last row wraps back to the top
  assign row_next = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  // state, cursor, fill counter and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      vram_w_en <= 1'b0;
      vram_addr <= VRAM_BASE;
      vram_dout <= BLANK;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      vram_w_en <= w_en_d;
      vram_addr <= addr_d;
      vram_dout <= dout_d;
    end
  end

  // next-state, cursor update and the write issued in the following cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    w_en_d  = 1'b0;
    addr_d  = vram_addr;
    dout_d  = vram_dout;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_FILL_SCREEN;
          w_en_d  = 1'b1;
          addr_d  = VRAM_BASE;
          dout_d  = BLANK;
          cnt_d   = 12'd1;
        end else if (char_valid) begin
          if (is_printable(char_in)) begin
            state_d = ST_PUT;
            w_en_d  = 1'b1;
            addr_d  = VRAM_BASE + {4'b0, cell_offset(row_q, col_q)};
            dout_d  = char_in;
            if (col_q == 7'(COLS - 1)) begin
              col_d  = '0;
              row_d  = row_next;
              wrap_d = 1'b1;
            end else begin
              col_d  = col_q + 7'd1;
              wrap_d = 1'b0;
            end
          end else if (char_in == ASCII_LF) begin
            state_d = ST_FILL_LINE;
            row_d   = row_next;
            w_en_d  = 1'b1;
            addr_d  = VRAM_BASE + {4'b0, cell_offset(row_next, 7'd0)};
            dout_d  = BLANK;
            cnt_d   = 12'd1;
          end else if (char_in == ASCII_CR) begin
            col_d = '0;
          end else if ((char_in == ASCII_BS) && (col_q != 7'd0)) begin
            state_d = ST_PUT;
            col_d   = col_q - 7'd1;
            wrap_d  = 1'b0;
            w_en_d  = 1'b1;
            addr_d  = VRAM_BASE + {4'b0, cell_offset(row_q, col_q - 7'd1)};
            dout_d  = BLANK;
          end
        end
      end
      ST_PUT: begin
        if (wrap_q) begin
          // row was already advanced on acceptance; blank it starting at column 0
          state_d = ST_FILL_LINE;
          wrap_d  = 1'b0;
          w_en_d  = 1'b1;
          addr_d  = VRAM_BASE + {4'b0, cell_offset(row_q, 7'd0)};
          dout_d  = BLANK;
          cnt_d   = 12'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL_LINE: begin
        if (cnt_q == 12'(COLS)) begin
          state_d = ST_IDLE;
        end else begin
          w_en_d = 1'b1;
          addr_d = VRAM_BASE + {4'b0, cell_offset(row_q, cnt_q[6:0])};
          cnt_d  = cnt_q + 12'd1;
        end
      end
      ST_FILL_SCREEN: begin
        if (cnt_q == 12'(COLS * ROWS)) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          w_en_d = 1'b1;
          addr_d = VRAM_BASE + {4'b0, cnt_q};
          cnt_d  = cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vram_console_writer.sv
// tb/tb_vram_console_writer.sv - randomized self-checking bench against a screen-level reference model
module tb_vram_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clear;
  logic [15:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        vram_w_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int m_col = 0;
  int m_row = 0;
  logic [23:0] exp_q[$];

  vram_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear      (clear),
    .vram_addr  (vram_addr),
    .vram_dout  (vram_dout),
    .vram_w_en  (vram_w_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: expected write list and cursor, in screen terms
  task automatic push_write(input int offset, input logic [7:0] data);
    logic [15:0] a;
    a = 16'h2000 + 16'(offset);
    exp_q.push_back({a, data});
  endtask

  task automatic blank_row(input int row);
    for (int c = 0; c < 80; c++) push_write(row * 80 + c, 8'h20);
  endtask

  task automatic model_char(input logic [7:0] c, output int lat);
    lat = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_write(m_row * 80 + m_col, c);
      lat = 1;
      if (m_col == 79) begin
        m_col = 0;
        m_row = (m_row + 1) % 30;
        blank_row(m_row);
        lat = 81;
      end else begin
        m_col++;
      end
    end else if (c == 8'h0A) begin
      m_row = (m_row + 1) % 30;
      blank_row(m_row);
      lat = 80;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_write(m_row * 80 + m_col, 8'h20);
        lat = 1;
      end
    end
  endtask

  // every write strobe must match the next write the model predicts
  always @(negedge clk) begin
    if (!rst && vram_w_en) begin
      if (exp_q.size() == 0) begin
        check("stray_write", {31'b0, vram_w_en}, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {8'b0, vram_addr, vram_dout}, {8'b0, e});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'b0, char_ready}, 32'd1);
  endtask

  task automatic count_busy(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_lat);
    check("queue_drained", exp_q.size(), 32'd0);
    check("ready_after_op", {31'b0, char_ready}, 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c);
    int lat;
    wait_ready();
    model_char(c, lat);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
    count_busy(lat, "op_busy_cycles");
  endtask

  task automatic do_clear(input logic with_char);
    wait_ready();
    clear      = 1'b1;
    char_valid = with_char;
    char_in    = 8'h41;
    #1;
    check("ready_low_on_clear", {31'b0, char_ready}, 32'd0);
    for (int i = 0; i < 2400; i++) push_write(i, 8'h20);
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    char_valid = 1'b0;
    count_busy(2400, "clear_busy_cycles");
    check("clear_cursor_col", cursor_col, 32'd0);
    check("clear_cursor_row", cursor_row, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_w_en"}, {31'b0, vram_w_en}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_addr"}, vram_addr, 32'h2000);
    check({tag, "_dout"}, vram_dout, 32'h20);
    check({tag, "_col"}, cursor_col, 32'd0);
    check({tag, "_row"}, cursor_row, 32'd0);
  endtask

  initial begin
    int r;
    logic [7:0] c;
    rst        = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    clear      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {31'b0, char_ready}, 32'd1);

    // first printable lands at the home cell
    send_char(8'h41);
    check("a_col", cursor_col, 32'd1);

    // fill row 0 to column 79, then wrap with 'Z'
    for (int i = 0; i < 78; i++) send_char(8'h61 + 8'(i % 26));
    check("at_col79", cursor_col, 32'd79);
    send_char(8'h5A);
    check("z_wrap_col", cursor_col, 32'd0);
    check("z_wrap_row", cursor_row, 32'd1);

    // walk to row 29, column 5, then LF wraps to row 0
    for (int i = 0; i < 28; i++) send_char(8'h0A);
    send_char(8'h0D);
    for (int i = 0; i < 5; i++) send_char(8'h30);
    check("at_row29", cursor_row, 32'd29);
    send_char(8'h0A);
    check("lf_wrap_col", cursor_col, 32'd5);
    check("lf_wrap_row", cursor_row, 32'd0);

    // backspace at (3,2), then at column 0
    send_char(8'h0D);
    send_char(8'h0A);
    send_char(8'h0A);
    for (int i = 0; i < 3; i++) send_char(8'h78);
    send_char(8'h08);
    check("bs_col", cursor_col, 32'd2);
    send_char(8'h0D);
    send_char(8'h08);
    check("bs0_col", cursor_col, 32'd0);
    check("bs0_row", cursor_row, 32'd2);

    // unrecognised control byte is consumed silently
    send_char(8'h01);

    // clear with a competing char
    do_clear(1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 78) c = 8'h0A;
      else if (r < 83) c = 8'h0D;
      else if (r < 94) c = 8'h08;
      else if (r < 99) c = 8'($urandom_range(0, 8'h1F));
      else             c = 8'hFF;
      if ($urandom_range(0, 199) == 0) do_clear(1'($urandom_range(0, 1)));
      send_char(c);
    end

    // reset in the middle of a screen fill
    send_char(8'h51);
    wait_ready();
    clear = 1'b1;
    for (int i = 0; i < 2400; i++) push_write(i, 8'h20);
    @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (999) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midfill_reset");
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_char(8'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
